// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default register-file geometry and writeback requester indices.
package cpu_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned AW_DEF   = 5;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_LSU = 1'b1
   } req_e;

   function automatic req_e other_req(input req_e r);
      return (r == REQ_ALU) ? REQ_LSU : REQ_ALU;
   endfunction

endpackage

// File: rtl/regfile_wb_arb_if.sv
// Writeback, issue-reservation and hazard-query signals between the pipeline and regfile_wb_arb.
interface regfile_wb_arb_if import cpu_pkg::*; #(
   parameter int unsigned XLEN = XLEN_DEF,
   parameter int unsigned AW   = AW_DEF
);

   logic            alu_valid;
   logic            alu_ready;
   logic [AW-1:0]   alu_rd;
   logic [XLEN-1:0] alu_data;

   logic            lsu_valid;
   logic            lsu_ready;
   logic [AW-1:0]   lsu_rd;
   logic [XLEN-1:0] lsu_data;

   logic            we;
   logic [AW-1:0]   rd_addr;
   logic [XLEN-1:0] rd_data;

   logic            issue_valid;
   logic            issue_ready;
   logic [AW-1:0]   issue_rd;

   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic            rs1_busy;
   logic            rs2_busy;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output lsu_valid, lsu_rd, lsu_data,
      output issue_valid, issue_rd,
      output rs1_addr, rs2_addr,
      input  alu_ready, lsu_ready, issue_ready,
      input  we, rd_addr, rd_data,
      input  rs1_busy, rs2_busy
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  lsu_valid, lsu_rd, lsu_data,
      input  issue_valid, issue_rd,
      input  rs1_addr, rs2_addr,
      output alu_ready, lsu_ready, issue_ready,
      output we, rd_addr, rd_data,
      output rs1_busy, rs2_busy
   );

endinterface

// File: rtl/wb_scoreboard.sv
// Per-register pending bits: set on destination reservation, cleared on writeback transfer.
module wb_scoreboard import cpu_pkg::*; #(
   parameter int unsigned AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          set_en,
   input  logic [AW-1:0] set_addr,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic [AW-1:0] issue_addr,
   output logic          issue_busy,
   input  logic [AW-1:0] rs1_addr,
   output logic          rs1_busy,
   input  logic [AW-1:0] rs2_addr,
   output logic          rs2_busy
);

   localparam int unsigned NumRegs = 1 << AW;

   logic [NumRegs-1:0] pending_q;
   logic [NumRegs-1:0] pending_d;

   // Set is applied after clear so a same-edge reservation of a retiring register survives.
   always_comb begin
      pending_d = pending_q;
      if (clr_en) begin
         pending_d[clr_addr] = 1'b0;
      end
      if (set_en) begin
         pending_d[set_addr] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign issue_busy = pending_q[issue_addr];
   assign rs1_busy   = pending_q[rs1_addr];
   assign rs2_busy   = pending_q[rs2_addr];

endmodule

// File: rtl/regfile_wb_arb.sv
// Two-requester register-file writeback arbiter with WAW/RAW scoreboard.
// Define REGFILE_WB_RR_EN for round-robin conflict resolution; default is fixed LSU priority.
module regfile_wb_arb import cpu_pkg::*; #(
   parameter int unsigned XLEN = XLEN_DEF,
   parameter int unsigned AW   = AW_DEF
) (
   input logic             clk,
   input logic             rst,
   regfile_wb_arb_if.slave bus
);

   logic            alu_nz;
   logic            lsu_nz;
   logic            conflict;
   req_e            win;

   logic            alu_ready;
   logic            lsu_ready;
   logic            issue_ready;
   logic            issue_busy;
   logic            set_en;

   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [XLEN-1:0] wr_data;

   logic            we_q;
   logic [AW-1:0]   rd_addr_q;
   logic [XLEN-1:0] rd_data_q;

   assign alu_nz   = bus.alu_valid && (bus.alu_rd != '0);
   assign lsu_nz   = bus.lsu_valid && (bus.lsu_rd != '0);
   assign conflict = alu_nz && lsu_nz;

`ifdef REGFILE_WB_RR_EN
   req_e ptr_q;
   req_e ptr_d;

   // Pointer holds the last conflict winner; the other requester takes the next conflict.
   assign win = other_req(ptr_q);

   always_comb begin
      ptr_d = ptr_q;
      if (conflict) begin
         ptr_d = win;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= REQ_LSU;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   assign win = REQ_LSU;
`endif

   // A zero-destination requester never writes, so it is always accepted.
   always_comb begin
      alu_ready = 1'b0;
      lsu_ready = 1'b0;
      if (!rst) begin
         alu_ready = (bus.alu_rd == '0) || !conflict || (win == REQ_ALU);
         lsu_ready = (bus.lsu_rd == '0) || !conflict || (win == REQ_LSU);
      end
   end

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = rd_addr_q;
      wr_data = rd_data_q;
      if (alu_nz && alu_ready) begin
         wr_en   = 1'b1;
         wr_addr = bus.alu_rd;
         wr_data = bus.alu_data;
      end else if (lsu_nz && lsu_ready) begin
         wr_en   = 1'b1;
         wr_addr = bus.lsu_rd;
         wr_data = bus.lsu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q      <= 1'b0;
         rd_addr_q <= '0;
         rd_data_q <= '0;
      end else begin
         we_q      <= wr_en;
         rd_addr_q <= wr_addr;
         rd_data_q <= wr_data;
      end
   end

   assign issue_ready = !rst && !((bus.issue_rd != '0) && issue_busy);
   assign set_en      = bus.issue_valid && issue_ready && (bus.issue_rd != '0);

   wb_scoreboard #(
      .AW (AW)
   ) u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .set_en     (set_en),
      .set_addr   (bus.issue_rd),
      .clr_en     (wr_en),
      .clr_addr   (wr_addr),
      .issue_addr (bus.issue_rd),
      .issue_busy (issue_busy),
      .rs1_addr   (bus.rs1_addr),
      .rs1_busy   (bus.rs1_busy),
      .rs2_addr   (bus.rs2_addr),
      .rs2_busy   (bus.rs2_busy)
   );

   assign bus.alu_ready   = alu_ready;
   assign bus.lsu_ready   = lsu_ready;
   assign bus.issue_ready = issue_ready;
   assign bus.we          = we_q;
   assign bus.rd_addr     = rd_addr_q;
   assign bus.rd_data     = rd_data_q;

endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter AW, default 5, register address width (2**AW registers; register 0 hardwired zero).
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have ports alu_valid/alu_ready (in/out, 1), alu_rd (in, AW), alu_data (in, XLEN): ALU writeback requester 0.
REQ-006 SHALL have ports lsu_valid/lsu_ready (in/out, 1), lsu_rd (in, AW), lsu_data (in, XLEN): load-unit writeback requester 1.
REQ-007 SHALL have ports we (out, 1), rd_addr (out, AW), rd_data (out, XLEN): single register-file write port.
REQ-008 SHALL have ports issue_valid (in, 1), issue_ready (out, 1), issue_rd (in, AW): destination reservation from decode.
REQ-009 SHALL have ports rs1_addr, rs2_addr (in, AW) and rs1_busy, rs2_busy (out, 1): operand hazard query.

Function
REQ-010 SHALL transfer a writeback on a cycle where valid && ready for that requester; requester holds valid and payload stable until transfer.
REQ-011 SHALL drive ready combinationally: a requester whose rd == 0 is always ready and never drives we.
REQ-012 SHALL, with exactly one nonzero-rd requester valid, assert that requester's ready.
REQ-013 SHALL, with both nonzero-rd requesters valid (conflict), grant exactly one; loser's ready = 0.
REQ-014 SHALL register the winning write: we/rd_addr/rd_data valid the cycle after the transfer (latency 1); we = 0 on cycles with no nonzero-rd transfer; rd_addr/rd_data hold prior values when we = 0.
REQ-015 SHALL keep a pending bit per register; pending[0] always 0.
REQ-016 SHALL set pending[issue_rd] at the edge where issue_valid && issue_ready && issue_rd != 0.
REQ-017 SHALL drive issue_ready = 0 when issue_rd != 0 and pending[issue_rd] = 1 (WAW blocked), else 1.
REQ-018 SHALL clear pending[r] at the edge where a nonzero-rd writeback to r transfers (same edge that loads we).
REQ-019 SHALL, if set and clear target the same register at the same edge, leave the bit set.
REQ-020 SHALL drive rsN_busy = pending[rsN_addr] combinationally, 0 for address 0; no bypass of the in-flight write.

Reset
REQ-021 SHALL, while rst = 1 at an edge, clear all pending bits, we, rd_addr, rd_data and the arbitration pointer; any writeback or issue handshaking in that cycle is discarded.
REQ-022 SHALL hold alu_ready, lsu_ready, issue_ready at 0 while rst = 1.

Configuration
REQ-023 SHALL, with macro REGFILE_WB_RR_EN defined, resolve conflicts round-robin: pointer records last conflict winner; other requester wins next conflict; reset pointer = requester 1, so ALU wins first conflict; pointer updates only on conflict cycles.
REQ-024 SHALL, without REGFILE_WB_RR_EN, resolve conflicts with fixed priority, LSU always winning; pointer absent.

Structure
REQ-025 SHALL place XLEN/AW defaults and the requester index enum (REQ_ALU = 0, REQ_LSU = 1) in shared package cpu_pkg.
REQ-026 SHALL implement the pending vector and busy lookup as sub-module wb_scoreboard; arbitration and write register stay in the top.

Verification
REQ-027 SHALL check single request: alu_valid, alu_rd = 3, alu_data = 0xDEADBEEF -> alu_ready = 1 same cycle; next cycle we = 1, rd_addr = 3, rd_data = 0xDEADBEEF.
REQ-028 SHALL check conflict: alu (rd = 4, 0x11) and lsu (rd = 5, 0x22) held valid 2 cycles -> with REGFILE_WB_RR_EN writes rd 4 then rd 5; without it rd 5 then rd 4.
REQ-029 SHALL check scoreboard: issue rd = 7 -> rs1_addr = 7 gives rs1_busy = 1; second issue rd = 7 sees issue_ready = 0; lsu writeback rd = 7 -> busy = 0 the cycle after transfer.
REQ-030 SHALL check same-edge set/clear: issue rd = 9 while writeback rd = 9 transfers -> pending[9] = 1 after edge.
REQ-031 SHALL check zero register: alu_rd = 0 with lsu rd = 6 valid -> both ready same cycle, one write to rd 6 only; issue rd = 0 leaves all busy = 0.
REQ-032 SHALL check reset mid-operation: rst during pending[2] = 1 and a transfer -> next cycle we = 0, rs1_busy(2) = 0, all ready = 0 during reset.
